// File: rtl/fifo_rd_pkg.sv
// Shared types and default widths for the FIFO burst reader slice.
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } rd_state_e;

    localparam int unsigned DEF_DATA_WIDTH = 16;
    localparam int unsigned DEF_BURST_LEN  = 4;
    localparam int unsigned DEF_CNT_WIDTH  = 16;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry skid buffer between the FIFO read port and the output stream.
// The head entry drives the stream; a push and pop in the same cycle keep occupancy.
module fifo_rd_skid
    import fifo_rd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [1:0]            occ,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  full
);

    logic [1:0]            occ_q, occ_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic                  push_ok, pop_ok;

    assign pop_ok  = pop & (occ_q != 2'd0);
    assign push_ok = push & ((occ_q != 2'd2) | pop_ok);

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        case ({push_ok, pop_ok})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    head_d = push_data;
                end else begin
                    tail_d = push_data;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                // Head leaves; the new word lands behind whatever remains.
                if (occ_q == 2'd1) begin
                    head_d = push_data;
                end else begin
                    head_d = tail_q;
                    tail_d = push_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    assign occ       = occ_q;
    assign head_data = head_q;
    assign full      = (occ_q == 2'd2);

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains a one-cycle-latency FIFO into a valid/ready stream framed in fixed bursts.
// Holds the run/halt FSM, read issue, beat and word counters and the sticky underflow flag.
module fifo_burst_reader
    import fifo_rd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned BURST_LEN  = DEF_BURST_LEN,
    parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  err_clr,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  err_underflow,
    output logic [CNT_WIDTH-1:0]  word_count
);

    localparam int unsigned BEAT_W = (BURST_LEN > 2) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);

    rd_state_e             state_q, state_d;
    logic                  inflight_q, inflight_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [CNT_WIDTH-1:0]  word_count_q, word_count_d;
    logic                  err_q, err_d;

    logic [1:0]            occ;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  full;
    logic                  pop;
    logic [31:0]           supply_next;
    logic [31:0]           remain_next;
    logic                  room_ok;
    logic                  want_more;

    fifo_rd_skid #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data (fifo_data_out),
        .pop       (pop),
        .occ       (occ),
        .head_data (head_data),
        .full      (full)
    );

    assign m_valid = (occ != 2'd0);
    assign m_data  = head_data;
    assign pop     = m_valid & m_ready;
    assign m_last  = m_valid & (beat_q == BEAT_LAST);

    always_comb begin
        beat_d       = beat_q;
        word_count_d = word_count_q;
        if (pop) begin
            beat_d       = (beat_q == BEAT_LAST) ? '0 : beat_q + BEAT_W'(1);
            word_count_d = word_count_q + CNT_WIDTH'(1);
        end
    end

    // With en low, reads only top up the words still owed to the open burst,
    // measured after this cycle's pop so the decision is never a cycle late.
    always_comb begin
        supply_next = 32'(occ) + 32'(inflight_q) - 32'(pop);
        remain_next = (beat_d == '0) ? 32'd0 : 32'(BURST_LEN) - 32'(beat_d);
        room_ok     = (supply_next < 32'd2) & ~(full & ~pop);
        want_more   = en | (supply_next < remain_next);
        fifo_rd_en  = ~rst & (state_q == RUN) & ~fifo_empty & room_ok & want_more;
    end

    assign inflight_d = fifo_rd_en;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (en) state_d = RUN;
            RUN: begin
                if (fifo_underflow) begin
                    state_d = HALT;
                end else if (!en && beat_q == '0 && !inflight_q && occ == 2'd0) begin
                    state_d = IDLE;
                end
            end
            HALT: if (err_clr) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        err_d = err_q;
        if (fifo_underflow) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            inflight_q   <= 1'b0;
            beat_q       <= '0;
            word_count_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            inflight_q   <= inflight_d;
            beat_q       <= beat_d;
            word_count_q <= word_count_d;
            err_q        <= err_d;
        end
    end

    assign busy          = (state_q != IDLE) | inflight_q | (occ != 2'd0);
    assign err_underflow = err_q;
    assign word_count    = word_count_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Randomized bench for fifo_burst_reader with a queue-style FIFO model and
// an in-order stream scoreboard that frames bursts by accepted-word count.
module tb_fifo_burst_reader;

    localparam int DW = 16;
    localparam int BL = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          err_clr = 1'b0;
    logic          fifo_underflow = 1'b0;
    logic          m_ready = 1'b0;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic          m_valid;
    logic          m_last;
    logic          busy;
    logic          err_underflow;
    logic [DW-1:0] fifo_data_out = '0;
    logic [DW-1:0] m_data;
    logic [CW-1:0] word_count;

    always #5 clk = ~clk;

    fifo_burst_reader #(
        .DATA_WIDTH(DW),
        .BURST_LEN (BL),
        .CNT_WIDTH (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .err_clr       (err_clr),
        .fifo_empty    (fifo_empty),
        .fifo_underflow(fifo_underflow),
        .fifo_data_out (fifo_data_out),
        .fifo_rd_en    (fifo_rd_en),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_last        (m_last),
        .m_ready       (m_ready),
        .busy          (busy),
        .err_underflow (err_underflow),
        .word_count    (word_count)
    );

    // FIFO model: array with pointers, one-cycle read latency, never reset.
    logic [DW-1:0] mem [0:4095];
    int            wr_ptr = 0;
    int            rd_ptr = 0;

    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_data_out <= mem[rd_ptr];
            rd_ptr        <= rd_ptr + 1;
        end
    end

    task automatic push_word(input logic [DW-1:0] d);
        mem[wr_ptr] = d;
        wr_ptr++;
    endtask

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: words must leave in FIFO order, every BL-th accepted word
    // carries last, and no more than two words are ever read ahead.
    int            acc = 0;
    int            issued = 0;
    int            exp_ptr = 0;
    logic          hold_valid = 1'b0;
    logic [DW-1:0] hold_data = '0;
    logic          halted = 1'b0;

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            acc        = 0;
            issued     = 0;
            exp_ptr    = rd_ptr;
            hold_valid = 1'b0;
        end else begin
            if (hold_valid) begin
                check_val("hold_valid", m_valid, 1);
                check_val("hold_data", m_data, hold_data);
            end
            if (fifo_rd_en) begin
                check_val("rd_on_empty", fifo_empty, 0);
                issued++;
            end
            if (halted) check_val("rd_in_halt", fifo_rd_en, 0);
            if (!m_valid) check_val("last_without_valid", m_last, 0);
            if (m_valid && m_ready) begin
                check_val("data_order", m_data, mem[exp_ptr]);
                check_val("last_framing", m_last, ((acc % BL) == BL - 1));
                check_val("word_count", word_count, acc & 32'hFFFF);
                acc++;
                exp_ptr++;
            end
            check_val("read_ahead_le2", (issued - acc) <= 2, 1);
            hold_valid = m_valid && !m_ready;
            hold_data  = m_data;
        end
    end

    task automatic drain_to_idle(input string tag);
        int t;
        en      = 1'b0;
        m_ready = 1'b1;
        t = 0;
        while (busy && t < 300) begin
            @(posedge clk); #1;
            if (fifo_empty) push_word(DW'($urandom));
            t++;
        end
        check_val({tag, "_idle"}, busy, 0);
        check_val({tag, "_burst_whole"}, acc % BL, 0);
    endtask

    task automatic random_phase(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 1) == 1) push_word(DW'($urandom));
            m_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) en = ~en;
        end
    endtask

    initial begin
        int t;
        int i0;

        // Reset with data waiting in the FIFO.
        for (int i = 0; i < 8; i++) push_word(DW'(i + 1));
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_m_valid", m_valid, 0);
        check_val("rst_m_data", m_data, 0);
        check_val("rst_m_last", m_last, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_err", err_underflow, 0);
        check_val("rst_word_count", word_count, 0);
        check_val("rst_rd_en", fifo_rd_en, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check_val("no_rd_while_disabled", issued, 0);

        // Streaming 0x0001..0x0008.
        @(posedge clk); #1;
        en      = 1'b1;
        m_ready = 1'b1;
        t = 0;
        while (!fifo_rd_en && t < 20) begin
            @(negedge clk); #1;
            t++;
        end
        check_val("first_rd_seen", fifo_rd_en, 1);
        @(negedge clk); #1;
        check_val("latency_cycle1", m_valid, 0);
        @(negedge clk); #1;
        check_val("latency_cycle2", m_valid, 1);
        repeat (7) @(negedge clk);
        #1;
        check_val("stream_8_back_to_back", acc, 8);
        @(posedge clk); #1;
        check_val("stream_word_count", word_count, 8);
        check_val("stream_empty_stall", m_valid, 0);

        // Back-pressure mid-stream.
        for (int i = 0; i < 12; i++) push_word(DW'($urandom));
        repeat (4) @(posedge clk);
        #1;
        m_ready = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        check_val("bp_two_held", issued - acc, 2);
        check_val("bp_rd_stopped", fifo_rd_en, 0);
        check_val("bp_valid_held", m_valid, 1);
        @(posedge clk); #1;
        m_ready = 1'b1;

        // Disable part way through a burst.
        for (int i = 0; i < 16; i++) push_word(DW'($urandom));
        t = 0;
        do begin
            @(negedge clk); #1;
            t++;
        end while ((acc % BL) != 2 && t < 40);
        check_val("dis_reached_beat2", acc % BL, 2);
        @(posedge clk); #1;
        en = 1'b0;
        t = 0;
        while (busy && t < 50) begin
            @(negedge clk); #1;
            t++;
        end
        check_val("dis_busy_clear", busy, 0);
        check_val("dis_burst_whole", acc % BL, 0);
        i0 = issued;
        repeat (4) @(negedge clk);
        #1;
        check_val("dis_fifo_has_data", fifo_empty, 0);
        check_val("dis_no_new_reads", issued, i0);

        // Underflow and clear together: set wins.
        @(posedge clk); #1;
        fifo_underflow = 1'b1;
        err_clr        = 1'b1;
        @(posedge clk); #1;
        fifo_underflow = 1'b0;
        err_clr        = 1'b0;
        check_val("err_set_wins", err_underflow, 1);
        check_val("err_idle_stays_idle", busy, 0);
        @(posedge clk); #1;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        check_val("err_clr_in_idle", err_underflow, 0);

        random_phase(400);
        drain_to_idle("rand1");

        // Underflow while running.
        for (int i = 0; i < 10; i++) push_word(DW'($urandom));
        @(posedge clk); #1;
        en      = 1'b1;
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        fifo_underflow = 1'b1;
        @(posedge clk); #1;
        fifo_underflow = 1'b0;
        halted         = 1'b1;
        check_val("uf_err_set", err_underflow, 1);
        check_val("uf_no_read", fifo_rd_en, 0);
        repeat (6) @(negedge clk);
        #1;
        check_val("uf_drained", m_valid, 0);
        check_val("uf_halt_busy", busy, 1);
        check_val("uf_fifo_untouched", fifo_empty, 0);
        @(posedge clk); #1;
        en      = 1'b0;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        halted  = 1'b0;
        check_val("uf_err_cleared", err_underflow, 0);
        check_val("uf_back_to_idle", busy, 0);

        // Asynchronous reset with the buffer full.
        for (int i = 0; i < 4; i++) push_word(DW'($urandom));
        @(posedge clk); #1;
        en      = 1'b1;
        m_ready = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check_val("ar_buffer_full", m_valid, 1);
        check_val("ar_two_held", issued - acc, 2);
        #1;
        rst = 1'b1;
        #1;
        check_val("ar_m_valid", m_valid, 0);
        check_val("ar_m_last", m_last, 0);
        check_val("ar_word_count", word_count, 0);
        check_val("ar_busy", busy, 0);
        check_val("ar_rd_en", fifo_rd_en, 0);
        #1;
        rst = 1'b0;

        random_phase(300);
        drain_to_idle("rand2");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Downstream drain stage for the synchronous FIFO. It pops words through the FIFO's one-cycle-latency read port and buffers them in a 2-entry skid buffer. It presents the words on a valid/ready stream, framed into fixed-length bursts with a `last` marker. It stalls cleanly on FIFO empty or consumer back-pressure, and latches any FIFO underflow as a sticky error that halts reading.

## Interface
- `DATA_WIDTH`, 16: FIFO word and stream data width.
- `BURST_LEN`, 4: words per burst, at least 2. `m_last` marks every BURST_LEN-th accepted word.
- `CNT_WIDTH`, 16: width of the accepted-word counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  enables issuing reads.
- `err_clr`  in  1  clears the sticky error; pulse.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_underflow`  in  1  FIFO underflow flag.
- `fifo_data_out`  in  DATA_WIDTH  FIFO read data, valid the cycle after `fifo_rd_en`.
- `fifo_rd_en`  out  1  FIFO pop request.
- `m_data`  out  DATA_WIDTH  stream data.
- `m_valid`  out  1  stream valid.
- `m_last`  out  1  final word of a burst.
- `m_ready`  in  1  consumer ready.
- `busy`  out  1  state is not IDLE, or a word is in flight or buffered.
- `err_underflow`  out  1  sticky underflow error.
- `word_count`  out  CNT_WIDTH  accepted words; wraps modulo 2^CNT_WIDTH.

## Operation
- FSM states are IDLE, RUN and HALT.
  - IDLE → RUN when `en`=1.
  - RUN → IDLE when `en`=0, `beat_cnt`=0, no read is in flight and the buffer is empty.
  - RUN → HALT when `fifo_underflow`=1.
  - HALT → IDLE on `err_clr`. `err_clr` in any other state only clears the error flag.
- Read issue: `fifo_rd_en` = (state=RUN) & !`fifo_empty` & (occ + inflight − pop < 2).
  - `occ` is buffer occupancy, 0 to 2.
  - `inflight` is `fifo_rd_en` registered.
  - `pop` = `m_valid` & `m_ready`.
  - `fifo_rd_en` is combinational and is 0 while `rst` is high.
- RUN with `en`=0: no new bursts start. Reads continue until `beat_cnt` returns to 0, so a burst is never truncated by `en`. An empty FIFO simply stalls the burst.
- Capture: when `inflight`=1, `fifo_data_out` is written into the buffer at the next edge. The buffer never overflows; the issue rule guarantees it.
- Stream: `m_valid` = occ>0 and `m_data` = head entry. Data and valid stay stable until accepted.
- `beat_cnt` counts 0 to BURST_LEN−1 on each pop and wraps to 0. `m_last` = `m_valid` & (`beat_cnt`=BURST_LEN−1).
- `word_count` increments on each pop.
- HALT: no reads are issued. Buffered and in-flight words are still delivered.
- `err_underflow` is set on `fifo_underflow`=1 in any state and cleared by `err_clr`. If both occur in the same cycle, set wins.

## Timing
- Reset values: `fifo_rd_en`=0, `m_valid`=0, `m_data`=0, `m_last`=0, `busy`=0, `err_underflow`=0, `word_count`=0, `beat_cnt`=0, state=IDLE. Reset asserted mid-burst discards buffered words immediately.
- Latency: with `fifo_rd_en` sampled at edge N, the word is captured at edge N+1 and `m_valid`=1 after edge N+1.
- Throughput: one word per cycle is sustained while the FIFO is non-empty and `m_ready`=1.
- Empty boundary: `fifo_rd_en` drops in the same cycle `fifo_empty` rises. No read is issued on empty.
- Back-pressure: with `m_ready`=0, at most 2 words are held and `fifo_rd_en` is 0 once occ+inflight=2.
- Simultaneous capture and pop: occ is unchanged and data shifts correctly.

## Structure
- `fifo_rd_pkg` holds the state enum `rd_state_e` (IDLE, RUN, HALT) and default width constants.
- Sub-module `fifo_rd_skid`: 2-entry buffer with push, pop, `occ`, head data and full flag.
- `fifo_burst_reader` holds the FSM, issue logic, `beat_cnt`, `word_count` and the error flag.

## Test plan
- Reset then idle: `rst`=1 with FIFO holding data → all outputs 0 and `fifo_rd_en`=0. After release with `en`=0 → no reads.
- Streaming: `en`=1, `m_ready`=1, FIFO preloaded with 8 words 0x0001–0x0008 → 8 consecutive `m_valid` beats, first 2 cycles after the first `fifo_rd_en`. `m_last` on 0x0004 and 0x0008; `word_count`=8.
- Back-pressure: `m_ready`=0 for 10 cycles mid-stream → exactly 2 extra pops, then `fifo_rd_en`=0. `m_data` is stable and no word is lost or duplicated after release.
- Disable mid-burst: `en`=0 after word 2 of a burst → words 3–4 are still delivered with `m_last` on 4, then IDLE and `busy`=0.
- Underflow: force `fifo_underflow`=1 for one cycle → `err_underflow`=1 and state HALT. Buffered words drain, no reads occur; `err_clr` → IDLE and error flag 0.
- Async reset mid-stream: `rst` pulse between edges with occ=2 → `m_valid`=0 immediately and counters 0.
